// File: rtl/pb_ssd_scanner.sv
// pb_ssd_scanner: PicoBlaze port-mapped N-digit seven-segment scanner.
// Each digit has a hex/dp/blank register. A control register holds a global
// enable and a 3-bit brightness that PWMs the lit time within each digit slot.
module pb_ssd_scanner #(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned SCAN_DIV_BITS = 18,
    parameter logic [7:0]  PORT_BASE     = 8'h10,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic                  ClkPort,
    input  logic                  Reset_n,
    input  logic                  write_strobe,
    input  logic [7:0]            port_id,
    input  logic [7:0]            out_port,
    output logic [7:0]            rd_data,
    output logic                  rd_hit,
    output logic [NUM_DIGITS-1:0] An,
    output logic [6:0]            Cathodes,
    output logic                  Dp
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PW    = SCAN_DIV_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]       CTRL_PORT = 8'(PORT_BASE + NUM_DIGITS);

    logic [5:0]            digit_q [NUM_DIGITS];
    logic [5:0]            digit_d [NUM_DIGITS];
    logic [3:0]            ctrl_q, ctrl_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    // Active-low abcdefg pattern for one hex nibble.
    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // State register: reset forces blank digits, enabled full brightness, dark outputs.
    always_ff @(posedge ClkPort) begin
        if (!Reset_n) begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                digit_q[d] <= 6'b100000;
            end
            ctrl_q  <= 4'b1111;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q   <= {7{ACTIVE_LOW}};
            dp_q    <= ACTIVE_LOW;
        end else begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                digit_q[d] <= digit_d[d];
            end
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    // Register file writes from the PicoBlaze output port; unused bits dropped.
    always_comb begin
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            digit_d[d] = digit_q[d];
        end
        ctrl_d = ctrl_q;
        if (write_strobe) begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                if (port_id == 8'(PORT_BASE + d)) begin
                    digit_d[d] = 6'(out_port);
                end
            end
            if (port_id == CTRL_PORT) begin
                ctrl_d = 4'(out_port);
            end
        end
    end

    // Prescaler and digit index; both parked at zero while disabled.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!ctrl_q[0]) begin
            presc_d = '0;
            idx_d   = '0;
        end else begin
            presc_d = presc_q + PW'(1);
            if (presc_q == '1) begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // Display drive for the next edge: one anode lit during the PWM window only.
    always_comb begin
        logic [5:0]            cur;
        logic                  lit;
        logic [NUM_DIGITS-1:0] an_act;
        logic [6:0]            seg_act;
        logic                  dp_act;
        cur = 6'b100000;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) begin
                cur = digit_q[d];
            end
        end
        lit     = ctrl_q[0] & ~cur[5] & (presc_q[PW-1 -: 3] <= ctrl_q[3:1]);
        an_act  = '0;
        seg_act = '0;
        dp_act  = 1'b0;
        if (lit) begin
            an_act  = NUM_DIGITS'(1) << idx_q;
            seg_act = ~hex7seg(cur[3:0]);
            dp_act  = cur[4];
        end
        an_d  = {NUM_DIGITS{ACTIVE_LOW}} ^ an_act;
        seg_d = {7{ACTIVE_LOW}} ^ seg_act;
        dp_d  = ACTIVE_LOW ^ dp_act;
    end

    // Read-back mux for the PicoBlaze input port.
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (port_id == 8'(PORT_BASE + d)) begin
                rd_data = {2'b00, digit_q[d]};
                rd_hit  = 1'b1;
            end
        end
        if (port_id == CTRL_PORT) begin
            rd_data = {4'h0, ctrl_q};
            rd_hit  = 1'b1;
        end
    end

    assign An       = an_q;
    assign Cathodes = seg_q;
    assign Dp       = dp_q;

endmodule

// File: tb/tb_pb_ssd_scanner.sv
// Bench for pb_ssd_scanner: an 8-digit and a 5-digit instance (4-bit prescaler).
// Stimulus pushes expected display/read values into queues; a negedge monitor
// pops and compares them against the DUT outputs.
module tb_pb_ssd_scanner;

    localparam int SLOT = 16;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] cath;
        logic       dp;
    } scan_t;

    typedef struct {
        int         cyc;
        int         u;
        logic [7:0] port;
        logic [7:0] d;
        logic       h;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ws  [2];
    logic [7:0] pid [2];
    logic [7:0] op  [2];
    logic [7:0] rdd0, rdd1;
    logic       rdh0, rdh1;
    logic [7:0] an0;
    logic [4:0] an1;
    logic [6:0] cath0, cath1;
    logic       dp0, dp1;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    scan_t sq0[$];
    scan_t sq1[$];
    rd_t   rq[$];

    // Reference state of each instance.
    int         m_nd [2] = '{8, 5};
    logic [5:0] m_dig [2][8];
    logic       m_en [2];
    logic [2:0] m_br [2];
    int         m_org [2];

    pb_ssd_scanner #(.NUM_DIGITS(8), .SCAN_DIV_BITS(4), .PORT_BASE(8'h10), .ACTIVE_LOW(1'b1)) dut8 (
        .ClkPort(clk), .Reset_n(rst_n), .write_strobe(ws[0]), .port_id(pid[0]), .out_port(op[0]),
        .rd_data(rdd0), .rd_hit(rdh0), .An(an0), .Cathodes(cath0), .Dp(dp0));

    pb_ssd_scanner #(.NUM_DIGITS(5), .SCAN_DIV_BITS(4), .PORT_BASE(8'h10), .ACTIVE_LOW(1'b1)) dut5 (
        .ClkPort(clk), .Reset_n(rst_n), .write_strobe(ws[1]), .port_id(pid[1]), .out_port(op[1]),
        .rd_data(rdd1), .rd_hit(rdh1), .An(an1), .Cathodes(cath1), .Dp(dp1));

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] hexlo(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Expected outputs visible after the edge that ends cycle c-1.
    function automatic scan_t exp_scan(input int u, input int c, input logic rst);
        scan_t      e;
        int         j, idx, p;
        logic [5:0] dv;
        logic [7:0] mask;
        mask   = (u == 0) ? 8'hFF : 8'h1F;
        e.cyc  = c;
        e.an   = mask;
        e.cath = 7'h7F;
        e.dp   = 1'b1;
        if (rst && m_en[u]) begin
            j   = c - m_org[u] - 1;
            idx = (j / SLOT) % m_nd[u];
            p   = j % SLOT;
            dv  = m_dig[u][idx];
            if (!dv[5] && (p / 2) <= int'(m_br[u])) begin
                e.an   = mask & ~(8'(1) << idx);
                e.cath = hexlo(dv[3:0]);
                e.dp   = ~dv[4];
            end
        end
        return e;
    endfunction

    task automatic model_update();
        int p;
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                for (int d = 0; d < 8; d++) m_dig[u][d] = 6'h20;
                m_en[u]  = 1'b1;
                m_br[u]  = 3'd7;
                m_org[u] = cyc;
            end else if (ws[u]) begin
                p = int'(pid[u]) - 16;
                if (p >= 0 && p < m_nd[u]) begin
                    m_dig[u][p] = op[u][5:0];
                end else if (p == m_nd[u]) begin
                    if (op[u][0] && !m_en[u]) m_org[u] = cyc;
                    m_en[u] = op[u][0];
                    m_br[u] = op[u][3:1];
                end
            end
        end
    endtask

    // One clock: queue expectations for the coming edge, then advance the model.
    task automatic tick();
        sq0.push_back(exp_scan(0, cyc + 1, rst_n));
        sq1.push_back(exp_scan(1, cyc + 1, rst_n));
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int u, input logic [7:0] p, input logic [7:0] d);
        ws[u]  = 1'b1;
        pid[u] = p;
        op[u]  = d;
        tick();
        ws[u]  = 1'b0;
    endtask

    task automatic rd(input int u, input logic [7:0] p, input logic [7:0] d, input logic h);
        rd_t r;
        pid[u] = p;
        r.cyc  = cyc;
        r.u    = u;
        r.port = p;
        r.d    = d;
        r.h    = h;
        rq.push_back(r);
        tick();
    endtask

    task automatic restart(input int u, input logic [7:0] ctrl_port, input logic [7:0] ctrl);
        wr(u, ctrl_port, ctrl & 8'hFE);
        wr(u, ctrl_port, ctrl);
    endtask

    task automatic chk_scan(input int u, input scan_t e);
        logic [7:0] a;
        logic [6:0] c;
        logic       d;
        a = (u == 0) ? an0 : {3'b000, an1};
        c = (u == 0) ? cath0 : cath1;
        d = (u == 0) ? dp0 : dp1;
        n_tests++;
        if (e.cyc != cyc || a !== e.an || c !== e.cath || d !== e.dp) begin
            n_fail++;
            $display("FAIL scan u%0d cyc %0d (exp cyc %0d): got An=%h Cath=%b Dp=%b, want An=%h Cath=%b Dp=%b",
                     u, cyc, e.cyc, a, c, d, e.an, e.cath, e.dp);
        end
    endtask

    task automatic chk_rd(input rd_t r);
        logic [7:0] d;
        logic       h;
        d = (r.u == 0) ? rdd0 : rdd1;
        h = (r.u == 0) ? rdh0 : rdh1;
        n_tests++;
        if (r.cyc != cyc || d !== r.d || h !== r.h) begin
            n_fail++;
            $display("FAIL read u%0d port %h cyc %0d: got data=%h hit=%b, want data=%h hit=%b",
                     r.u, r.port, cyc, d, h, r.d, r.h);
        end
    endtask

    // Monitor: compare every expectation due by this cycle.
    always @(negedge clk) begin
        while (sq0.size() > 0 && sq0[0].cyc <= cyc) chk_scan(0, sq0.pop_front());
        while (sq1.size() > 0 && sq1[0].cyc <= cyc) chk_scan(1, sq1.pop_front());
        while (rq.size() > 0 && rq[0].cyc <= cyc) chk_rd(rq.pop_front());
    end

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            ws[u]  = 1'b0;
            pid[u] = 8'h00;
            op[u]  = 8'h00;
        end

        // Reset and idle: everything dark, control reads enabled/bright 7.
        run(3);
        rst_n = 1'b1;
        run(20);
        rd(0, 8'h18, 8'h0F, 1'b1);
        rd(0, 8'h20, 8'h00, 1'b0);
        rd(0, 8'h10, 8'h20, 1'b1);
        rd(0, 8'h17, 8'h20, 1'b1);
        rd(0, 8'h0F, 8'h00, 1'b0);
        rd(1, 8'h15, 8'h0F, 1'b1);
        rd(1, 8'h16, 8'h00, 1'b0);

        // Digit 0 shows '3' with dp; unused bits and unmapped writes are dropped.
        wr(0, 8'h10, 8'h13);
        restart(0, 8'h18, 8'h0F);
        run(8 * SLOT + 4);
        rd(0, 8'h10, 8'h13, 1'b1);
        wr(0, 8'h11, 8'hE5);
        wr(0, 8'h20, 8'h00);
        wr(0, 8'h0F, 8'h00);
        rd(0, 8'h11, 8'h25, 1'b1);
        rd(0, 8'h10, 8'h13, 1'b1);

        // Brightness: bright 0, then bright 3 changed on the fly, then full.
        restart(0, 8'h18, 8'h01);
        run(2 * SLOT + 3);
        wr(0, 8'h18, 8'h07);
        run(8 * SLOT);
        wr(0, 8'h18, 8'hFF);
        rd(0, 8'h18, 8'h0F, 1'b1);
        run(SLOT);

        // Unblank all digits, disable mid-slot of digit 3, re-enable from digit 0.
        wr(0, 8'h11, 8'h0A);
        wr(0, 8'h12, 8'h1B);
        wr(0, 8'h13, 8'h0C);
        wr(0, 8'h14, 8'h1D);
        wr(0, 8'h15, 8'h0E);
        wr(0, 8'h16, 8'h3F);
        wr(0, 8'h17, 8'h07);
        restart(0, 8'h18, 8'h0F);
        run(3 * SLOT + 5);
        wr(0, 8'h18, 8'h0E);
        run(10);
        wr(0, 8'h18, 8'h0F);
        run(2 * SLOT);

        // Write the next digit on the slot-wrap edge.
        restart(0, 8'h18, 8'h0F);
        run(SLOT - 1);
        wr(0, 8'h11, 8'h08);
        run(SLOT + 4);

        // Five-digit instance: index wraps 4 -> 0.
        for (int d = 0; d < 5; d++) wr(1, 8'(8'h10 + d), 8'(d));
        restart(1, 8'h15, 8'h0F);
        run(2 * 5 * SLOT + 8);

        // Reset mid-scan with simultaneous writes: writes lost.
        rst_n  = 1'b0;
        ws[0]  = 1'b1; pid[0] = 8'h10; op[0] = 8'h05;
        ws[1]  = 1'b1; pid[1] = 8'h12; op[1] = 8'h09;
        tick();
        rst_n  = 1'b1;
        ws[0]  = 1'b0;
        ws[1]  = 1'b0;
        run(10);
        rd(0, 8'h10, 8'h20, 1'b1);
        rd(0, 8'h18, 8'h0F, 1'b1);
        rd(1, 8'h12, 8'h20, 1'b1);
        rd(1, 8'h15, 8'h0F, 1'b1);
        wr(0, 8'h10, 8'h02);
        run(2 * SLOT);

        @(negedge clk);
        #1;
        n_tests++;
        if (sq0.size() + sq1.size() + rq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", sq0.size() + sq1.size() + rq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
